// File: rtl/smem_pkg.sv
// Shared types and constants for the smem request controller.
// State encodings are plain constants so legacy code can compare against them directly.
package smem_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StSetup  = 3'd1;
  localparam state_t StAccess = 3'd2;
  localparam state_t StWait   = 3'd3;
  localparam state_t StResp   = 3'd4;

  localparam int unsigned PerrCntWidth = 8;

  typedef logic [1:0] lat_cnt_t;

  // Read latency of the memory as seen from the strobe edge.
  function automatic lat_cnt_t rd_lat(input bit dout_pipeline);
    return dout_pipeline ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/smem_ctrl.sv
// Single-outstanding request initiator for the smem block: strobes the memory,
// waits out its pipelining, captures read data with a parity check and holds the response.
module smem_ctrl
  import smem_pkg::*;
#(
  parameter int unsigned MEM_WIDTH     = 16,
  parameter int unsigned ADDR_SIZE     = 10,
  parameter string       ADDR_PIPELINE = "FALSE",
  parameter string       DOUT_PIPELINE = "TRUE",
  parameter bit          PARITY_ENABLE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  // request channel
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_SIZE-1:0]    req_addr,
  input  logic [MEM_WIDTH-1:0]    req_wdata,
  // response channel
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [MEM_WIDTH-1:0]    rsp_rdata,
  output logic                    rsp_perr,
  output logic [PerrCntWidth-1:0] perr_cnt,
  // memory pins
  output logic [MEM_WIDTH-1:0]    mem_din,
  output logic [ADDR_SIZE-1:0]    mem_addr,
  output logic                    mem_wr_en,
  output logic                    mem_rd_en,
  output logic                    mem_blk_select,
  output logic                    mem_addr_en,
  output logic                    mem_dout_en,
  input  logic [MEM_WIDTH-1:0]    mem_dout,
  input  logic                    mem_parity_out
);

  localparam bit       AddrPipe = (ADDR_PIPELINE == "TRUE");
  localparam bit       DoutPipe = (DOUT_PIPELINE == "TRUE");
  localparam lat_cnt_t RdLat    = rd_lat(DoutPipe);

  state_t                  state_q, state_d;
  lat_cnt_t                cnt_q, cnt_d;
  logic                    wr_q;
  logic [ADDR_SIZE-1:0]    addr_q;
  logic [MEM_WIDTH-1:0]    wdata_q;
  logic [MEM_WIDTH-1:0]    rdata_q;
  logic                    perr_q;
  logic [PerrCntWidth-1:0] perr_cnt_q;

  logic accept;
  logic capture;
  logic busy;
  logic perr_now;

  assign accept  = (state_q == StIdle) && req_valid;
  assign capture = (state_q == StWait) && (cnt_q == '0);
  assign busy    = (state_q == StSetup) || (state_q == StAccess) || (state_q == StWait);

  // The memory drives parity_out as the inverse of dout[0].
  assign perr_now = PARITY_ENABLE && (mem_parity_out != ~mem_dout[0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = AddrPipe ? StSetup : StAccess;
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        if (wr_q) begin
          state_d = StIdle;
        end else begin
          state_d = StWait;
          cnt_d   = RdLat - 2'd1;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      perr_q     <= 1'b0;
      perr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (capture) begin
        rdata_q <= mem_dout;
        perr_q  <= perr_now;
        if (perr_now && (perr_cnt_q != '1)) begin
          perr_cnt_q <= perr_cnt_q + PerrCntWidth'(1);
        end
      end
    end
  end

  always_comb begin
    req_ready      = (state_q == StIdle);
    rsp_valid      = (state_q == StResp);
    rsp_rdata      = rdata_q;
    rsp_perr       = perr_q;
    perr_cnt       = perr_cnt_q;
    mem_blk_select = busy;
    mem_addr       = busy ? addr_q : '0;
    mem_din        = busy ? wdata_q : '0;
    mem_wr_en      = (state_q == StAccess) && wr_q;
    mem_rd_en      = (state_q == StAccess) && !wr_q;
    mem_addr_en    = 1'b1;
    mem_dout_en    = 1'b1;
  end

endmodule

// File: tb/tb_smem_ctrl.sv
// Directed bench for smem_ctrl: a default instance and an address-pipelined,
// unpipelined-output, parity-disabled instance, each driving a small memory model.
module tb_smem_ctrl;

  localparam int unsigned W = 16;
  localparam int unsigned A = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic         a_req_valid, a_req_ready, a_req_write;
  logic [A-1:0] a_req_addr;
  logic [W-1:0] a_req_wdata;
  logic         a_rsp_valid, a_rsp_ready, a_rsp_perr;
  logic [W-1:0] a_rsp_rdata;
  logic [7:0]   a_perr_cnt;
  logic [W-1:0] a_mem_din, a_mem_dout;
  logic [A-1:0] a_mem_addr;
  logic         a_wr, a_rd, a_blk, a_addr_en, a_dout_en, a_parity;
  logic         a_force = 1'b0;

  // Instance B: address pipeline, no output pipeline, parity check off
  logic         b_req_valid, b_req_ready, b_req_write;
  logic [A-1:0] b_req_addr;
  logic [W-1:0] b_req_wdata;
  logic         b_rsp_valid, b_rsp_ready, b_rsp_perr;
  logic [W-1:0] b_rsp_rdata;
  logic [7:0]   b_perr_cnt;
  logic [W-1:0] b_mem_din, b_mem_dout;
  logic [A-1:0] b_mem_addr;
  logic         b_wr, b_rd, b_blk, b_addr_en, b_dout_en, b_parity;
  logic         b_force = 1'b0;

  smem_ctrl u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_perr(a_rsp_perr), .perr_cnt(a_perr_cnt),
    .mem_din(a_mem_din), .mem_addr(a_mem_addr), .mem_wr_en(a_wr), .mem_rd_en(a_rd),
    .mem_blk_select(a_blk), .mem_addr_en(a_addr_en), .mem_dout_en(a_dout_en),
    .mem_dout(a_mem_dout), .mem_parity_out(a_parity)
  );

  smem_ctrl #(
    .ADDR_PIPELINE("TRUE"),
    .DOUT_PIPELINE("FALSE"),
    .PARITY_ENABLE(1'b0)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_perr(b_rsp_perr), .perr_cnt(b_perr_cnt),
    .mem_din(b_mem_din), .mem_addr(b_mem_addr), .mem_wr_en(b_wr), .mem_rd_en(b_rd),
    .mem_blk_select(b_blk), .mem_addr_en(b_addr_en), .mem_dout_en(b_dout_en),
    .mem_dout(b_mem_dout), .mem_parity_out(b_parity)
  );

  // Memory models: A has two read stages, B has one.
  logic [W-1:0] a_mem [1024];
  logic [W-1:0] b_mem [1024];
  logic [W-1:0] a_r1 = '0;
  logic [W-1:0] a_r2 = '0;
  logic [W-1:0] b_r1 = '0;

  always @(posedge clk) begin
    if (a_wr) a_mem[a_mem_addr] <= a_mem_din;
    if (a_rd) a_r1 <= a_mem[a_mem_addr];
    a_r2 <= a_r1;
    if (b_wr) b_mem[b_mem_addr] <= b_mem_din;
    if (b_rd) b_r1 <= b_mem[b_mem_addr];
  end

  assign a_mem_dout = a_r2;
  assign b_mem_dout = b_r1;
  assign a_parity   = a_force ? 1'b1 : ~a_mem_dout[0];
  assign b_parity   = b_force ? 1'b1 : ~b_mem_dout[0];

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int a_hold_err;

  task automatic a_write(input logic [A-1:0] addr, input logic [W-1:0] data);
    a_req_valid = 1'b1;
    a_req_write = 1'b1;
    a_req_addr  = addr;
    a_req_wdata = data;
    tick;
    a_req_valid = 1'b0;
    tick;
  endtask

  task automatic a_read(input logic [A-1:0] addr, input int hold, input logic frc,
                        output logic [W-1:0] rdata, output logic perr, output int lat);
    a_force     = frc;
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b1;
    a_req_write = 1'b0;
    a_req_addr  = addr;
    tick;
    a_req_valid = 1'b0;
    lat = 0;
    while (!a_rsp_valid && lat < 20) begin
      tick;
      lat++;
    end
    rdata = a_rsp_rdata;
    perr  = a_rsp_perr;
    a_hold_err = 0;
    for (int i = 0; i < hold; i++) begin
      tick;
      if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== rdata || a_rsp_perr !== perr ||
          a_req_ready !== 1'b0) a_hold_err++;
    end
    a_rsp_ready = 1'b1;
    tick;
    a_rsp_ready = 1'b0;
    a_force     = 1'b0;
  endtask

  logic [W-1:0] rd;
  logic         pe;
  int           lat;
  int           pulses;
  int           pat_err;
  int           viol;

  initial begin
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0;
    a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    b_rsp_ready = 1'b0;
    tick;
    tick;

    // Reset state
    check_eq("rst_req_ready", 32'(a_req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", 32'(a_rsp_rdata), 32'd0);
    check_eq("rst_rsp_perr", 32'(a_rsp_perr), 32'd0);
    check_eq("rst_perr_cnt", 32'(a_perr_cnt), 32'd0);
    check_eq("rst_strobes", 32'({a_wr, a_rd, a_blk}), 32'd0);
    check_eq("rst_mem_addr", 32'(a_mem_addr), 32'd0);
    check_eq("tie_en", 32'({a_addr_en, a_dout_en}), 32'd3);
    rst = 1'b0;

    // Write 0x1234 to address 5, one busy cycle
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 10'd5; a_req_wdata = 16'h1234;
    tick;
    a_req_valid = 1'b0;
    check_eq("wr_access_strobes", 32'({a_wr, a_rd, a_blk}), 32'b101);
    check_eq("wr_access_addr", 32'(a_mem_addr), 32'd5);
    check_eq("wr_access_din", 32'(a_mem_din), 32'h1234);
    check_eq("wr_access_ready", 32'(a_req_ready), 32'd0);
    tick;
    check_eq("wr_done_ready", 32'(a_req_ready), 32'd1);
    check_eq("wr_done_idle_pins", 32'({a_wr, a_blk, a_mem_din}), 32'd0);

    // Read it back
    a_read(10'd5, 0, 1'b0, rd, pe, lat);
    check_eq("rd_data", 32'(rd), 32'h1234);
    check_eq("rd_perr", 32'(pe), 32'd0);
    check_eq("rd_latency", 32'(lat), 32'd3);

    // Backpressure for 10 cycles
    a_read(10'd5, 10, 1'b0, rd, pe, lat);
    check_eq("bp_hold_stable", 32'(a_hold_err), 32'd0);
    check_eq("bp_data", 32'(rd), 32'h1234);
    check_eq("bp_ready_after", 32'(a_req_ready), 32'd1);
    check_eq("bp_valid_after", 32'(a_rsp_valid), 32'd0);

    // Forced parity errors on a read of 0x0003
    a_write(10'd7, 16'h0003);
    check_eq("perr_cnt_before", 32'(a_perr_cnt), 32'd0);
    a_read(10'd7, 0, 1'b1, rd, pe, lat);
    check_eq("perr_data", 32'(rd), 32'h0003);
    check_eq("perr_flag", 32'(pe), 32'd1);
    check_eq("perr_cnt_one", 32'(a_perr_cnt), 32'd1);
    for (int i = 1; i < 300; i++) a_read(10'd7, 0, 1'b1, rd, pe, lat);
    check_eq("perr_cnt_sat", 32'(a_perr_cnt), 32'd255);
    a_read(10'd7, 0, 1'b0, rd, pe, lat);
    check_eq("perr_clear_flag", 32'(pe), 32'd0);

    // Reset while in WAIT
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 10'd5;
    tick;
    a_req_valid = 1'b0;
    tick;
    check_eq("wait_blk", 32'({a_blk, a_rd}), 32'b10);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_eq("rstw_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check_eq("rstw_req_ready", 32'(a_req_ready), 32'd1);
    check_eq("rstw_blk", 32'(a_blk), 32'd0);
    check_eq("rstw_perr_cnt", 32'(a_perr_cnt), 32'd0);
    viol = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (a_rsp_valid !== 1'b0) viol++;
    end
    check_eq("rstw_no_rsp", 32'(viol), 32'd0);

    // Back-to-back writes with req_valid held high
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 10'd20; a_req_wdata = 16'h00A0;
    pulses = 0;
    pat_err = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (a_wr) pulses++;
      if (a_req_ready !== ((i % 2) == 1)) pat_err++;
      a_req_addr  = 10'(21 + i);
      a_req_wdata = 16'(16'h00A1 + i);
    end
    a_req_valid = 1'b0;
    check_eq("b2b_pulses", 32'(pulses), 32'd4);
    check_eq("b2b_ready_pattern", 32'(pat_err), 32'd0);
    tick;
    a_read(10'd22, 0, 1'b0, rd, pe, lat);
    check_eq("b2b_data_22", 32'(rd), 32'h00A2);
    a_read(10'd26, 0, 1'b0, rd, pe, lat);
    check_eq("b2b_data_26", 32'(rd), 32'h00A6);

    // Instance B: write 0xFFFF to 1023 with address setup
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 10'd1023; b_req_wdata = 16'hFFFF;
    tick;
    b_req_valid = 1'b0;
    check_eq("b_wr_setup", 32'({b_blk, b_wr, b_mem_addr}), 32'({1'b1, 1'b0, 10'd1023}));
    tick;
    check_eq("b_wr_access", 32'({b_blk, b_wr, b_mem_addr}), 32'({1'b1, 1'b1, 10'd1023}));
    check_eq("b_wr_busy", 32'(b_req_ready), 32'd0);
    tick;
    check_eq("b_wr_done", 32'({b_req_ready, b_wr}), 32'b10);

    // Instance B: read 1023 with a forced parity error that must be ignored
    b_force = 1'b1;
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 10'd1023;
    tick;
    b_req_valid = 1'b0;
    b_req_addr  = 10'd0;
    check_eq("b_rd_setup", 32'({b_blk, b_rd, b_mem_addr}), 32'({1'b1, 1'b0, 10'd1023}));
    tick;
    lat = 1;
    check_eq("b_rd_access", 32'({b_blk, b_rd, b_mem_addr}), 32'({1'b1, 1'b1, 10'd1023}));
    while (!b_rsp_valid && lat < 20) begin
      tick;
      lat++;
    end
    check_eq("b_rd_latency", 32'(lat), 32'd3);
    check_eq("b_rd_data", 32'(b_rsp_rdata), 32'hFFFF);
    check_eq("b_rd_perr_off", 32'(b_rsp_perr), 32'd0);
    check_eq("b_perr_cnt", 32'(b_perr_cnt), 32'd0);
    check_eq("b_resp_pins", 32'({b_blk, b_rd, b_mem_addr}), 32'd0);
    b_rsp_ready = 1'b1;
    tick;
    b_rsp_ready = 1'b0;
    b_force = 1'b0;
    check_eq("b_rsp_done", 32'({b_req_ready, b_rsp_valid}), 32'b10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
